// File: rtl/adder_pipe.sv
// Pipelined ripple-carry adder: the carry chain is cut into SEG-bit segments, one register stage each.
// Optional subtract mode is enabled by defining ADDER_PIPE_SUB_EN.
module adder_pipe #(
    parameter int WIDTH = 10,
    parameter int SEG   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);
    localparam int STAGES = (WIDTH + SEG - 1) / SEG;

    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef ADDER_PIPE_SUB_EN
    // a - b is computed as a + ~b + 1; the inversion is folded in before stage 0.
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    logic [STAGES-1:0] valid;
    logic [STAGES:0]   room;
    logic [WIDTH-1:0]  stage_a   [STAGES];
    logic [WIDTH-1:0]  stage_b   [STAGES];
    logic [WIDTH-1:0]  stage_res [STAGES];
    logic [STAGES-1:0] stage_c;

    // room[k]: stage k may load this cycle (empty, or its contents move on).
    always_comb begin
        room = '0;
        room[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            room[k] = ~valid[k] | room[k+1];
        end
    end

    assign in_ready = room[0];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO = gi * SEG;
            localparam int SW = ((WIDTH - LO) < SEG) ? (WIDTH - LO) : SEG;

            logic [WIDTH-1:0] src_a;
            logic [WIDTH-1:0] src_b;
            logic [WIDTH-1:0] src_res;
            logic             src_c;
            logic             src_v;
            logic [SW:0]      seg_sum;
            logic [WIDTH-1:0] res_next;
            logic [WIDTH-1:0] a_reg;
            logic [WIDTH-1:0] b_reg;
            logic [WIDTH-1:0] res_reg;
            logic             c_reg;
            logic             valid_reg;

            if (gi == 0) begin : g_head
                assign src_a   = a;
                assign src_b   = b_in;
                assign src_c   = c_in;
                assign src_res = '0;
                assign src_v   = in_valid;
            end else begin : g_body
                assign src_a   = stage_a[gi-1];
                assign src_b   = stage_b[gi-1];
                assign src_c   = stage_c[gi-1];
                assign src_res = stage_res[gi-1];
                assign src_v   = valid[gi-1];
            end

            assign seg_sum = {1'b0, src_a[LO +: SW]} + {1'b0, src_b[LO +: SW]}
                           + {{SW{1'b0}}, src_c};

            always_comb begin
                res_next = src_res;
                res_next[LO +: SW] = seg_sum[SW-1:0];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    a_reg     <= '0;
                    b_reg     <= '0;
                    res_reg   <= '0;
                    c_reg     <= 1'b0;
                end else if (room[gi]) begin
                    valid_reg <= src_v;
                    a_reg     <= src_a;
                    b_reg     <= src_b;
                    res_reg   <= res_next;
                    c_reg     <= seg_sum[SW];
                end
            end

            assign valid[gi]     = valid_reg;
            assign stage_a[gi]   = a_reg;
            assign stage_b[gi]   = b_reg;
            assign stage_res[gi] = res_reg;
            assign stage_c[gi]   = c_reg;
        end
    endgenerate

    assign out_valid = valid[STAGES-1];
    assign sum       = {stage_c[STAGES-1], stage_res[STAGES-1]};

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: a 10/5 instance and a 7/3 instance against an arithmetic model.
module tb_adder_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv10 = 1'b0, or10 = 1'b0, cin10 = 1'b0, sub10 = 1'b0;
    logic        ir10, ov10;
    logic [9:0]  a10 = '0, b10 = '0;
    logic [10:0] sum10;

    logic        iv7 = 1'b0, or7 = 1'b0, cin7 = 1'b0;
    logic        ir7, ov7;
    logic [6:0]  a7 = '0, b7 = '0;
    logic [7:0]  sum7;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp10[$], got10[$];
    logic [7:0]  exp7[$], got7[$];

    adder_pipe #(.WIDTH(10), .SEG(5)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10),
        .a(a10), .b(b10), .cin(cin10),
`ifdef ADDER_PIPE_SUB_EN
        .sub(sub10),
`endif
        .out_valid(ov10), .out_ready(or10), .sum(sum10)
    );

    adder_pipe #(.WIDTH(7), .SEG(3)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv7), .in_ready(ir7),
        .a(a7), .b(b7), .cin(cin7),
`ifdef ADDER_PIPE_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(ov7), .out_ready(or7), .sum(sum7)
    );

    function automatic logic [10:0] ref10(logic [9:0] x, logic [9:0] y, logic c, logic s);
        int r;
        if (s) r = int'(x) - int'(y) + 1024;
        else   r = int'(x) + int'(y) + int'(c);
        return r[10:0];
    endfunction

    function automatic logic [7:0] ref7(logic [6:0] x, logic [6:0] y, logic c);
        int r;
        r = int'(x) + int'(y) + int'(c);
        return r[7:0];
    endfunction

    // Records transfers on both instances for one clock; starts and ends at posedge+1.
    task automatic tick();
        @(negedge clk);
        if (iv10 && ir10) exp10.push_back(ref10(a10, b10, cin10, sub10));
        if (ov10 && or10) got10.push_back(sum10);
        if (iv7 && ir7)   exp7.push_back(ref7(a7, b7, cin7));
        if (ov7 && or7)   got7.push_back(sum7);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp10.delete(); got10.delete(); exp7.delete(); got7.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iv10 = 1'b1; iv7 = 1'b1; or10 = 1'b1; or7 = 1'b1;
        a10 = 10'($urandom); b10 = 10'($urandom); a7 = 7'($urandom); b7 = 7'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ov10 !== 1'b0) begin errors++; $display("FAIL reset_ov10: got %b want 0", ov10); end
        checks++; if (sum10 !== 11'd0) begin errors++; $display("FAIL reset_sum10: got %0d want 0", sum10); end
        checks++; if (ir10 !== 1'b1) begin errors++; $display("FAIL reset_ir10: got %b want 1", ir10); end
        checks++; if (ov7 !== 1'b0) begin errors++; $display("FAIL reset_ov7: got %b want 0", ov7); end
        checks++; if (sum7 !== 8'd0) begin errors++; $display("FAIL reset_sum7: got %0d want 0", sum7); end
        checks++; if (ir7 !== 1'b1) begin errors++; $display("FAIL reset_ir7: got %b want 1", ir7); end
        @(posedge clk); #1;
        iv10 = 1'b0; iv7 = 1'b0; rst_n = 1'b1;
        repeat (4) tick();
        checks++;
        if (got10.size() + got7.size() != 0 || ov10 !== 1'b0 || ov7 !== 1'b0) begin
            errors++;
            $display("FAIL reset_spurious: got %0d outputs want 0", got10.size() + got7.size());
        end
        $display("test_reset done");
        clear_q();
    endtask

    task automatic test_latency10();
        logic [9:0]  va [2];
        logic [9:0]  vb [2];
        logic        vc [2];
        logic [10:0] want [2];
        va = '{10'd1023, 10'd1023}; vb = '{10'd1, 10'd1023}; vc = '{1'b0, 1'b1};
        want = '{11'd1024, 11'd2047};
        or10 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a10 = va[i]; b10 = vb[i]; cin10 = vc[i]; iv10 = 1'b1;
            @(negedge clk);
            checks++; if (ir10 !== 1'b1) begin errors++; $display("FAIL lat10_ready[%0d]: got %b want 1", i, ir10); end
            @(posedge clk); #1;
            iv10 = 1'b0;
            checks++; if (ov10 !== 1'b0) begin errors++; $display("FAIL lat10_early[%0d]: got ov %b want 0", i, ov10); end
            @(posedge clk); #1;
            checks++;
            if (ov10 !== 1'b1 || sum10 !== want[i]) begin
                errors++;
                $display("FAIL lat10_sum[%0d]: got ov=%b sum=%0d want ov=1 sum=%0d", i, ov10, sum10, want[i]);
            end
            $display("latency10 %0d+%0d+%0d -> %0d", va[i], vb[i], vc[i], sum10);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        or10 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a10 = 10'($urandom); b10 = 10'($urandom); cin10 = 1'($urandom); iv10 = 1'b1;
            tick();
        end
        iv10 = 1'b0;
        repeat (4) tick();
        checks++; if (exp10.size() != 20) begin errors++; $display("FAIL b2b_accepts: got %0d want 20", exp10.size()); end
        checks++; if (got10.size() != 20) begin errors++; $display("FAIL b2b_results: got %0d want 20", got10.size()); end
        for (int i = 0; i < got10.size() && i < exp10.size(); i++) begin
            checks++;
            if (got10[i] !== exp10[i]) begin
                errors++;
                $display("FAIL b2b_sum[%0d]: got %0d want %0d", i, got10[i], exp10[i]);
            end else begin
                $display("b2b %0d: sum %0d", i, got10[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_stall();
        int prev;
        logic [10:0] held;
        held = '0;
        or10 = 1'b0; iv10 = 1'b1;
        a10 = 10'($urandom); b10 = 10'($urandom); cin10 = 1'($urandom);
        for (int c = 0; c < 5; c++) begin
            prev = exp10.size();
            tick();
            if (exp10.size() != prev) begin
                a10 = 10'($urandom); b10 = 10'($urandom); cin10 = 1'($urandom);
            end
            if (c == 2) held = sum10;
        end
        checks++; if (exp10.size() != 2) begin errors++; $display("FAIL stall_accepts: got %0d want 2", exp10.size()); end
        checks++; if (ir10 !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", ir10); end
        checks++;
        if (ov10 !== 1'b1 || sum10 !== held) begin
            errors++;
            $display("FAIL stall_hold: got ov=%b sum=%0d want ov=1 sum=%0d", ov10, sum10, held);
        end
        if (exp10.size() > 0) begin
            checks++;
            if (sum10 !== exp10[0]) begin errors++; $display("FAIL stall_value: got %0d want %0d", sum10, exp10[0]); end
        end
        iv10 = 1'b0; or10 = 1'b1;
        repeat (4) tick();
        checks++;
        if (got10.size() != exp10.size()) begin
            errors++;
            $display("FAIL stall_drain_count: got %0d want %0d", got10.size(), exp10.size());
        end
        for (int i = 0; i < got10.size() && i < exp10.size(); i++) begin
            checks++;
            if (got10[i] !== exp10[i]) begin
                errors++;
                $display("FAIL stall_drain[%0d]: got %0d want %0d", i, got10[i], exp10[i]);
            end else begin
                $display("stall drain %0d: sum %0d", i, got10[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_w7();
        or7 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a7 = 7'($urandom); b7 = 7'($urandom); cin7 = 1'($urandom); iv7 = 1'b1;
            tick();
        end
        iv7 = 1'b0;
        repeat (5) tick();
        checks++; if (got7.size() != 10 || exp7.size() != 10) begin errors++; $display("FAIL w7_count: got %0d/%0d want 10", got7.size(), exp7.size()); end
        for (int i = 0; i < got7.size() && i < exp7.size(); i++) begin
            checks++;
            if (got7[i] !== exp7[i]) begin
                errors++;
                $display("FAIL w7_sum[%0d]: got %0d want %0d", i, got7[i], exp7[i]);
            end else begin
                $display("w7 %0d: sum %0d", i, got7[i]);
            end
        end
        clear_q();

        a7 = 7'd127; b7 = 7'd1; cin7 = 1'b0; iv7 = 1'b1;
        @(negedge clk);
        checks++; if (ir7 !== 1'b1) begin errors++; $display("FAIL w7_ready: got %b want 1", ir7); end
        @(posedge clk); #1;
        iv7 = 1'b0;
        checks++; if (ov7 !== 1'b0) begin errors++; $display("FAIL w7_early1: got %b want 0", ov7); end
        @(posedge clk); #1;
        checks++; if (ov7 !== 1'b0) begin errors++; $display("FAIL w7_early2: got %b want 0", ov7); end
        @(posedge clk); #1;
        checks++;
        if (ov7 !== 1'b1 || sum7 !== 8'd128) begin
            errors++;
            $display("FAIL w7_latency: got ov=%b sum=%0d want ov=1 sum=128", ov7, sum7);
        end
        $display("w7 127+1 -> %0d", sum7);
        @(posedge clk); #1;

        or7 = 1'b0; iv7 = 1'b1;
        a7 = 7'($urandom); b7 = 7'($urandom);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov7 !== 1'b0 || ir7 !== 1'b1 || sum7 !== 8'd0) begin
            errors++;
            $display("FAIL w7_midreset: got ov=%b ir=%b sum=%0d want ov=0 ir=1 sum=0", ov7, ir7, sum7);
        end
        iv7 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; or7 = 1'b1;
        clear_q();
        repeat (5) tick();
        checks++;
        if (got7.size() != 0 || ov7 !== 1'b0) begin
            errors++;
            $display("FAIL w7_after_reset: got %0d outputs want 0", got7.size());
        end
        $display("w7 mid-flight reset done");
        clear_q();
    endtask

`ifdef ADDER_PIPE_SUB_EN
    task automatic test_sub();
        logic [9:0]  va [2];
        logic [9:0]  vb [2];
        logic [10:0] want [2];
        va = '{10'd5, 10'd7}; vb = '{10'd7, 10'd5}; want = '{11'h3FE, 11'h402};
        or10 = 1'b1; sub10 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a10 = va[i]; b10 = vb[i]; cin10 = 1'b1; iv10 = 1'b1;
            @(posedge clk); #1;
            iv10 = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (ov10 !== 1'b1 || sum10 !== want[i]) begin
                errors++;
                $display("FAIL sub[%0d]: got ov=%b sum=%h want ov=1 sum=%h", i, ov10, sum10, want[i]);
            end
            $display("sub %0d-%0d -> %h", va[i], vb[i], sum10);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 12; i++) begin
            a10 = 10'($urandom); b10 = 10'($urandom); cin10 = 1'($urandom);
            sub10 = 1'($urandom); iv10 = 1'b1;
            tick();
        end
        iv10 = 1'b0;
        repeat (4) tick();
        checks++; if (got10.size() != 12) begin errors++; $display("FAIL sub_count: got %0d want 12", got10.size()); end
        for (int i = 0; i < got10.size() && i < exp10.size(); i++) begin
            checks++;
            if (got10[i] !== exp10[i]) begin
                errors++;
                $display("FAIL sub_rand[%0d]: got %h want %h", i, got10[i], exp10[i]);
            end else begin
                $display("sub rand %0d: sum %h", i, got10[i]);
            end
        end
        sub10 = 1'b0;
        clear_q();
    endtask
`endif

    initial begin
        test_reset();
        test_latency10();
        test_back_to_back();
        test_stall();
        test_w7();
`ifdef ADDER_PIPE_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined ripple-carry adder that segments the carry chain across register stages so wide sums close timing at full clock rate. Operands enter through a valid/ready handshake, travel through one register stage per carry segment, and leave through a valid/ready handshake. It is the general successor to the fixed 10-bit combinational adder, used wherever a datapath needs registered, back-pressurable sums of arbitrary width.

## Interface
- WIDTH, 10, operand width in bits (>= 1)
- SEG, 5, bits of carry chain resolved per stage (1..WIDTH); STAGES = ceil(WIDTH/SEG)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- sub  input  1  subtract select (only with ADDER_PIPE_SUB_EN)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH+1  result; sum[WIDTH] is carry-out

## Operation
- Stage registers S0..S(STAGES-1), each with a valid bit; S(STAGES-1) drives sum/out_valid directly (registered outputs, no combinational path from a/b to sum).
- Segment k covers bits [k*SEG, min((k+1)*SEG, WIDTH)-1]; the top segment is narrower when SEG does not divide WIDTH.
- S0 loads segment 0 computed from a, b, cin; stage k>0 computes segment k from the carry held in S(k-1); untouched operand bits and finished result bits ride along unchanged.
- Result: sum = a + b + cin, exact, WIDTH+1 bits, no wrap or saturation.
- Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage k advances when it is valid and (k is last ? out_ready : stage k+1 is empty or advancing). Stage k loads when it is empty or advancing.
- in_ready = !valid[0] || stage 0 advancing (combinational from out_ready through the chain).
- Bubbles collapse: an empty stage accepts from upstream even while downstream is stalled.
- sum and out_valid hold steady while out_valid && !out_ready.
- Reset (any time, including mid-pipeline): all valid bits cleared and in-flight data discarded; out_valid=0, sum=0, in_ready=1 while rst_n is low and after release.

## Timing
- Latency: operands accepted on edge N appear on sum with out_valid=1 after edge N+STAGES-1 (STAGES cycles including acceptance cycle); WIDTH=10, SEG=5 -> 2 cycles.
- Throughput: one result per cycle while out_ready=1.
- Capacity: STAGES results in flight; when full and out_ready=0, in_ready=0.
- Simultaneous output pop and input push on a full pipe is allowed the same cycle (in_ready=1).
- Critical path: one SEG-bit ripple plus a carry register.

## Configuration
- ADDER_PIPE_SUB_EN defined: sub port exists; sub=1 computes a + ~b + 1 (cin ignored), so sum[WIDTH-1:0] = a-b mod 2^WIDTH and sum[WIDTH]=1 iff a >= b unsigned; sub is captured with the operands.
- ADDER_PIPE_SUB_EN undefined: no sub port; add only.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, sum=0, in_ready=1; release, no spurious output.
- WIDTH=10, SEG=5: a=1023, b=1, cin=0 accepted edge N -> sum=1024, out_valid=1 after edge N+1; a=1023, b=1023, cin=1 -> 2047.
- Back-to-back 20 random operand pairs with out_ready=1 -> 20 correct results, one per cycle, in order.
- Hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready drops after 2 accepts, sum stable; release -> no loss or duplication.
- WIDTH=7, SEG=3 (STAGES=3): a=127, b=1 -> sum=128 after 3 cycles; assert rst_n low mid-flight -> pipe empties, out_valid=0.
- With ADDER_PIPE_SUB_EN, WIDTH=10: a=5, b=7, sub=1 -> sum=0x3FE (sum[10]=0); a=7, b=5 -> sum=0x402 (sum[10]=1, low bits 2).
